// File: rtl/mult_pkg.sv
// Shared definitions for the sequential digit multiplier.
//   state_t   : controller states (IDLE, RUN, DONE)
//   DIGIT_W   : width of one operand digit fed to the 2x2 core
//   CORE_P_W  : width of the 2x2 core product
//   shift_amt : bit offset of the partial product for digit pair (i, j)
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DIGIT_W  = 2;
  localparam int CORE_P_W = 4;

  // Digit i of A has weight 4^i and digit j of B has weight 4^j, so
  // their product lands at bit offset 2*(i+j).
  function automatic int unsigned shift_amt(input int unsigned i,
                                            input int unsigned j);
    return 2 * (i + j);
  endfunction

endpackage

// File: rtl/digit_select.sv
// Digit selector for the sequential digit multiplier.
// Decodes the digit-pair counter into an A digit index i = cnt / D and a
// B digit index j = cnt % D (j is the inner loop). It returns both digits
// and the partial-product shift.
// Ports:
//   a_q, b_q : registered operands
//   cnt      : digit-pair counter
//   core_x   : A digit a_q[2i+1:2i]
//   core_y   : B digit b_q[2j+1:2j]
//   shift    : 2*(i+j), the bit offset of the core product
module digit_select
  import mult_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int D     = WIDTH / 2,
  parameter int CNT_W = 4,
  parameter int SH_W  = 4
) (
  input  logic [WIDTH-1:0]   a_q,
  input  logic [WIDTH-1:0]   b_q,
  input  logic [CNT_W-1:0]   cnt,
  output logic [DIGIT_W-1:0] core_x,
  output logic [DIGIT_W-1:0] core_y,
  output logic [SH_W-1:0]    shift
);

  logic [CNT_W-1:0] i_idx;
  logic [CNT_W-1:0] j_idx;

  always_comb begin
    i_idx  = cnt / CNT_W'(D);
    j_idx  = cnt % CNT_W'(D);
    // A digit index i starts at bit 2i, which is {i, 1'b0}.
    core_x = DIGIT_W'(a_q >> {i_idx, 1'b0});
    core_y = DIGIT_W'(b_q >> {j_idx, 1'b0});
    shift  = SH_W'(shift_amt(32'(i_idx), 32'(j_idx)));
  end

endmodule

// File: rtl/seq_digit_multiplier.sv
// Sequential WIDTH x WIDTH unsigned multiplier built around an external
// combinational 2x2 core. It accepts one operand pair per valid/ready
// handshake. It then walks all D*D digit pairs, one pair per cycle. Each
// shifted core product is added into a 2*WIDTH accumulator. The result is
// presented on a valid/ready output.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   in_valid/in_ready   : operand handshake
//   in_a, in_b          : unsigned operands
//   out_valid/out_ready : result handshake
//   out_product         : registered product in_a*in_b
//   core_x, core_y      : digits driven to the 2x2 core (0 outside RUN)
//   core_p              : 4-bit product returned by the core
module seq_digit_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_product,
  output logic [1:0]         core_x,
  output logic [1:0]         core_y,
  input  logic [3:0]         core_p
);

  localparam int D     = WIDTH / 2;
  localparam int CNT_W = (D * D > 1) ? $clog2(D * D) : 1;
  localparam int PW    = 2 * WIDTH;
  localparam int SH_W  = $clog2(PW);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(D * D - 1);

  state_t               state_q;
  state_t               state_d;
  logic [PW-1:0]        acc;
  logic [CNT_W-1:0]     cnt;
  logic [WIDTH-1:0]     a_q;
  logic [WIDTH-1:0]     b_q;
  logic [DIGIT_W-1:0]   x_sel;
  logic [DIGIT_W-1:0]   y_sel;
  logic [SH_W-1:0]      shift;

  digit_select #(
    .WIDTH (WIDTH),
    .D     (D),
    .CNT_W (CNT_W),
    .SH_W  (SH_W)
  ) u_digit_select (
    .a_q    (a_q),
    .b_q    (b_q),
    .cnt    (cnt),
    .core_x (x_sel),
    .core_y (y_sel),
    .shift  (shift)
  );

  // The core is only driven while digits are being consumed.
  assign core_x      = (state_q == RUN) ? x_sel : '0;
  assign core_y      = (state_q == RUN) ? y_sel : '0;
  assign out_product = acc;

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = RUN;
      end
      RUN: begin
        if (cnt == LAST) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      acc     <= '0;
      cnt     <= '0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q <= in_a;
            b_q <= in_b;
            acc <= '0;
            cnt <= '0;
          end
        end
        RUN: begin
          // Zero-extend before shifting so high partial products are kept.
          acc <= acc + (PW'(core_p) << shift);
          cnt <= (cnt == LAST) ? '0 : cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_digit_multiplier.sv
// Self-checking bench for seq_digit_multiplier (WIDTH=8).
module tb_seq_digit_multiplier;

  localparam int WIDTH = 8;
  localparam int D     = WIDTH / 2;
  localparam int DD    = D * D;

  logic                clk = 1'b0;
  logic                reset;
  logic                in_valid;
  logic                in_ready;
  logic [WIDTH-1:0]    in_a;
  logic [WIDTH-1:0]    in_b;
  logic                out_valid;
  logic                out_ready;
  logic [2*WIDTH-1:0]  out_product;
  logic [1:0]          core_x;
  logic [1:0]          core_y;
  logic [3:0]          core_p;

  int checks   = 0;
  int failures = 0;

  seq_digit_multiplier #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_product (out_product),
    .core_x      (core_x),
    .core_y      (core_y),
    .core_p      (core_p)
  );

  // Behavioural 2x2 core.
  assign core_p = {2'b00, core_x} * {2'b00, core_y};

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: tracks accepted operands, the digit pair being
  // consumed, and the queue of products still owed to the sink.
  int               phase = -1;
  logic [WIDTH-1:0] ma = '0;
  logic [WIDTH-1:0] mb = '0;
  logic [15:0]      sb[$];
  int               acc_cyc[$];
  int               cyc = 0;
  int               results = 0;
  logic             started = 1'b0;
  logic [15:0]      exp_p;
  logic [1:0]       ex;
  logic [1:0]       ey;

  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      phase = -1;
      sb.delete();
    end else if (started) begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_result: got %0d expected none", out_product);
        end else begin
          exp_p = sb.pop_front();
          check("sb_product", 32'(out_product), 32'(exp_p));
          results++;
        end
      end
      if (phase >= 0) begin
        phase = (phase == DD - 1) ? -1 : phase + 1;
      end else if (in_valid && in_ready) begin
        phase = 0;
        ma    = in_a;
        mb    = in_b;
        sb.push_back({8'b0, in_a} * {8'b0, in_b});
        acc_cyc.push_back(cyc);
      end
    end
  end

  always @(negedge clk) begin
    if (started && !reset) begin
      if (phase >= 0) begin
        ex = 2'(ma >> (2 * (phase / D)));
        ey = 2'(mb >> (2 * (phase % D)));
      end else begin
        ex = 2'b00;
        ey = 2'b00;
      end
      check("core_x", 32'(core_x), 32'(ex));
      check("core_y", 32'(core_y), 32'(ey));
    end
  end

  // Present an operand pair and hold it until accepted. Returns just after
  // the accepting edge with in_valid still high and scrambled operands.
  task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                      input bit rnd);
    int n = 0;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    while (!in_ready && n < 200) begin
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: got in_ready=0 expected 1");
    end
    @(posedge clk);
    #1;
    in_a = WIDTH'($urandom);
    in_b = WIDTH'($urandom);
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    forever begin
      @(negedge clk);
      if (out_valid) break;
      lat++;
      if (lat > 100) begin
        checks++;
        failures++;
        $display("FAIL valid_timeout: got out_valid=0 expected 1");
        break;
      end
    end
  endtask

  typedef struct {
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic [2*WIDTH-1:0] p;
  } vec_t;

  vec_t tbl[4];
  logic [WIDTH-1:0] b2b_a[3];
  logic [WIDTH-1:0] b2b_b[3];

  initial begin
    int lat;
    int r0;
    int n;

    tbl[0] = '{8'd13,  8'd11,  16'd143};
    tbl[1] = '{8'd255, 8'd255, 16'hFE01};
    tbl[2] = '{8'h00,  8'hAB,  16'h0000};
    tbl[3] = '{8'h01,  8'h80,  16'h0080};
    b2b_a  = '{8'd3, 8'd17, 8'd254};
    b2b_b  = '{8'd5, 8'd19, 8'd2};

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_product", 32'(out_product), 32'd0);
    check("rst_core_x", 32'(core_x), 32'd0);
    check("rst_core_y", 32'(core_y), 32'd0);
    started = 1'b1;
    reset   = 1'b0;
    @(negedge clk);

    // Directed vectors: latency and product.
    for (int i = 0; i < 4; i++) begin
      send(tbl[i].a, tbl[i].b, 1'b0);
      in_valid = 1'b0;
      wait_valid(lat);
      check("tbl_latency", 32'(lat), 32'(DD));
      check("tbl_product", 32'(out_product), 32'(tbl[i].p));
      @(negedge clk);
    end

    // Back-pressure: result held while the sink stalls.
    out_ready = 1'b0;
    send(8'd200, 8'd3, 1'b0);
    in_valid = 1'b0;
    wait_valid(lat);
    for (int k = 0; k < 10; k++) begin
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_product", 32'(out_product), 32'd600);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_valid", 32'(out_valid), 32'd0);
    check("bp_release_ready", 32'(in_ready), 32'd1);

    // Reset in the middle of a run.
    send(8'h55, 8'hAA, 1'b0);
    in_valid = 1'b0;
    @(negedge clk);
    repeat (7) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_product", 32'(out_product), 32'd0);
    send(8'd6, 8'd7, 1'b0);
    in_valid = 1'b0;
    wait_valid(lat);
    check("after_rst_product", 32'(out_product), 32'd42);
    @(negedge clk);

    // Back-to-back with in_valid held high.
    acc_cyc.delete();
    r0 = results;
    for (int k = 0; k < 3; k++) send(b2b_a[k], b2b_b[k], 1'b0);
    in_valid = 1'b0;
    n = 0;
    while (results < r0 + 3 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("b2b_results", 32'(results - r0), 32'd3);
    check("b2b_accepts", 32'(acc_cyc.size()), 32'd3);
    if (acc_cyc.size() == 3) begin
      check("b2b_spacing0", 32'(acc_cyc[1] - acc_cyc[0]), 32'(DD + 2));
      check("b2b_spacing1", 32'(acc_cyc[2] - acc_cyc[1]), 32'(DD + 2));
    end

    // Random operands with random sink stalls.
    for (int k = 0; k < 1000; k++) begin
      send(WIDTH'($urandom), WIDTH'($urandom), 1'b1);
      in_valid = 1'b0;
      repeat ($urandom_range(0, 2)) begin
        out_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
      end
    end
    out_ready = 1'b1;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("rnd_drain", 32'(sb.size()), 32'd0);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
